// File: rtl/uart_tx_pkg.sv
// Purpose : shared types and constants for the memory-mapped UART transmitter.
// Latency : n/a (package only).
// Backpres: n/a. Contents: serializer state enum, status bit positions, default addresses.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bit positions inside the status word.
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // Writing a 1 to this bit of the status register clears the sticky overflow.
  localparam int OVF_CLR_BIT = 3;

  localparam logic [15:0] DEF_TX_ADDR     = 16'hFFFF;
  localparam logic [15:0] DEF_STATUS_ADDR = 16'hFFFE;

endpackage

// File: rtl/sync_fifo.sv
// Purpose : single-clock circular-buffer FIFO with extra-MSB pointers for full/empty.
// Latency : pop_data shows the head combinationally; a push is visible after one edge.
// Backpres: a push is taken when not full or when a pop happens in the same cycle.
// Ports   : clk, rst (async, active-high), push/push_data, pop/pop_data, full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle; the
  // head is read before the edge, so the overlap is safe.
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Purpose : memory-mapped 8N1 UART transmitter snooping the CPU write port and read1 port.
// Latency : status read valid one cycle after the address hit; a byte into an idle, empty
//           unit is popped on the next edge and its start bit follows that edge.
// Backpres: none toward the CPU; a TX write into a full FIFO is dropped and sets sticky overflow.
// Ports   : clk, rst (async, active-high), mem_read_en/mem_read1_addr, mem_write_en/
//           mem_write_addr/mem_write_data, io_read_valid/io_read_data, uart_tx, tx_busy.
// Option  : define UART_TX_STATS_EN for a frames_sent counter at STATUS_ADDR-1.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [15:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic [15:0] mem_read1_addr,
  input  logic        mem_write_en,
  input  logic [15:0] mem_write_addr,
  input  logic [15:0] mem_write_data,
  output logic        io_read_valid,
  output logic [15:0] io_read_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          tx_d;
  logic          bit_done;
  logic          pop;

  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic          tx_wr, ovf_clr, ovf_set, overflow;
  logic          status_rd, rd_hit;
  logic [15:0]   status_word, rd_word;
  logic          unused_wdata;

  assign unused_wdata = ^mem_write_data[15:8];

  // ---------------- write decode ----------------
  assign tx_wr   = mem_write_en && (mem_write_addr == TX_ADDR);
  assign ovf_clr = mem_write_en && (mem_write_addr == STATUS_ADDR) && mem_write_data[OVF_CLR_BIT];
  assign ovf_set = tx_wr && fifo_full && !pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_wr),
    .push_data (mem_write_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= ovf_set | (overflow & ~ovf_clr);
  end

  assign tx_busy = (state != IDLE) || !fifo_empty;

  // ---------------- serializer FSM ----------------
  assign bit_done = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      cnt     <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      // The counter idles at zero, so popping into START starts a fresh bit period.
      cnt     <= (state == IDLE || bit_done) ? '0 : cnt + CW'(1);
      uart_tx <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decided from the next state so the registered output lines up with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- read path ----------------
  assign status_rd = mem_read_en && (mem_read1_addr == STATUS_ADDR);

  always_comb begin
    status_word             = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_BUSY]  = tx_busy;
    status_word[STAT_OVF]   = overflow;
  end

`ifdef UART_TX_STATS_EN
  localparam logic [15:0] STATS_ADDR = STATUS_ADDR - 16'd1;

  logic [15:0] frames_sent;
  logic        stats_rd, stats_clr;

  assign stats_rd  = mem_read_en && (mem_read1_addr == STATS_ADDR);
  assign stats_clr = mem_write_en && (mem_write_addr == STATS_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    frames_sent <= 16'd0;
    else if (stats_clr)                         frames_sent <= 16'd0;
    else if (state == STOP && state_d == IDLE)  frames_sent <= frames_sent + 16'd1;
  end

  assign rd_hit  = status_rd || stats_rd;
  assign rd_word = status_rd ? status_word : frames_sent;
`else
  assign rd_hit  = status_rd;
  assign rd_word = status_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_read_valid <= 1'b0;
      io_read_data  <= 16'd0;
    end else begin
      io_read_valid <= rd_hit;
      if (rd_hit) io_read_data <= rd_word;
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the downstream side of the pipelined CPU.
- Snoops the CPU data-memory write port and the second read port (read1).
- Writes to the TX data address push bytes into a FIFO.
- An 8N1 serializer drains the FIFO onto a serial line.
- A status register is readable with the same 1-cycle latency as data memory; the top-level muxes io_read_data over memory data when io_read_valid is high.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit. Minimum 2.
- FIFO_DEPTH, 16: TX FIFO entries. Power of two, 2..256.
- TX_ADDR, 16'hFFFF: write-only TX data register address.
- STATUS_ADDR, 16'hFFFE: status/control register address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read_en  in  1  CPU read enable.
- mem_read1_addr  in  16  CPU data read address.
- mem_write_en  in  1  CPU write enable.
- mem_write_addr  in  16  CPU write address.
- mem_write_data  in  16  CPU write data.
- io_read_valid  out  1  io_read_data is valid this cycle (address hit on previous cycle).
- io_read_data  out  16  registered read data.
- uart_tx  out  1  serial output; idle high.
- tx_busy  out  1  serializer not IDLE or FIFO not empty.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - uart_tx=1, io_read_valid=0, io_read_data=0, tx_busy=0.
  - FIFO empty; overflow=0; FSM=IDLE; baud counter=0; bit index=0.
- Reset asserted mid-frame forces uart_tx high immediately and discards FIFO contents.
- Write decode:
  - mem_write_en && mem_write_addr==TX_ADDR: push mem_write_data[7:0]; upper byte ignored.
  - Push is accepted if FIFO is not full, or if a pop occurs in the same cycle.
  - A push refused because the FIFO is full sets sticky overflow=1; the byte is dropped.
- Status write: mem_write_en && addr==STATUS_ADDR && data[3]==1 clears overflow. A clear and a new overflow in the same cycle leave overflow=1.
- Read:
  - If mem_read_en && mem_read1_addr==STATUS_ADDR on edge N, then io_read_valid=1 with io_read_data = {12'b0, overflow, tx_busy, full, empty} after edge N.
  - Otherwise io_read_valid=0 and io_read_data holds its previous value.
  - Status is sampled at edge N (pre-update values).
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers. full/empty come from the pointer MSB compare; pointers wrap naturally.
- Serializer FSM: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the head into an 8-bit shift register, clear the counter, go to START. uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] (LSB first) for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: a byte written on edge E0 into an empty FIFO with FSM IDLE is popped on E1. The start bit appears after E1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly one IDLE cycle between the stop bit and the next start bit.
- uart_tx is registered (glitch-free).
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO: both succeed; count unchanged.
  - Push into an empty FIFO while FSM IDLE: pop happens on the next edge, not the same one.
- Baud counter counts 0..CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT).

Optional Feature:
- Macro: UART_TX_STATS_EN.
- Defined:
  - 16-bit frames_sent counter, incremented on each STOP->IDLE transition and wrapping at 16'hFFFF->0.
  - Readable at STATUS_ADDR-1 (16'hFFFD by default) with the same 1-cycle valid protocol.
  - A write to that address clears it to 0.
  - Reset value is 0.
- Undefined: no counter logic; that address is not decoded and io_read_valid stays 0 for it.

Decomposition:
- Package uart_tx_pkg:
  - State enum (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Status bit index constants (EMPTY=0, FULL=1, BUSY=2, OVF=3).
  - Default address constants.
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty, with asynchronous active-high rst.
- FSM, baud counter and address decode remain in uart_tx_mmio.

Test Plan:
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset check: assert rst mid-operation -> uart_tx=1, io_read_valid=0, status read returns 16'h0001.
- Single byte: write 16'h12A5 to 16'hFFFF -> uart_tx low 1 cycle later for 4 cycles. Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. Total 40 cycles. tx_busy drops after STOP.
- Overflow: write 6 bytes back-to-back to 16'hFFFF -> first is popped, 4 buffered, 6th dropped. Status read = 16'h000E (ovf, busy, full). Write 16'h0008 to 16'hFFFE -> overflow=0.
- Back-to-back: write 8'h00 then 8'hFF -> two frames separated by exactly one idle-high cycle. Received bytes 00 and FF.
- Read latency: read 16'hFFFE on edge N -> io_read_valid=1 only in cycle N+1. Read of 16'h1234 -> io_read_valid=0.
- With UART_TX_STATS_EN: send 3 bytes, read 16'hFFFD -> 16'h0003. Write 16'hFFFD -> reads 16'h0000.
